uart_axi_master: RTL

//  Byte-level AXI4-Lite master to the AXI UART Lite core; sits directly downstream of io_fsm.

---
 rtl/uart_axi_master_if.sv | 30 +++
 rtl/uart_axi_master.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_axi_master_if.sv
// rtl/uart_axi_master_if.sv - AXI4-Lite bus bundle between uart_axi_master and the AXI UART Lite core
interface uart_axi_master_if;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/uart_axi_master.sv
// rtl/uart_axi_master.sv - byte-level AXI4-Lite master polling STAT and moving bytes through the UART Lite FIFOs
module uart_axi_master #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axi_re,
    input  logic              axi_we,
    input  logic [1:0]        axi_sel,
    input  logic [7:0]        tx_data,
    output logic [7:0]        rx_data,
    output logic              axi_r_success,
    output logic              axi_r_timeout,
    output logic              axi_w_success,
    output logic              axi_w_busy,
    uart_axi_master_if.master m_axi
);
    localparam logic [3:0] ADDR_RX   = 4'h0;
    localparam logic [3:0] ADDR_TX   = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [3:0] {
        IDLE, RS_AR, RS_R, RX_AR, RX_R, WS_AR, WS_R, W_AW, W_B
    } state_t;

    state_t      state;
    logic [31:0] counter;
    logic        armed;
    logic [7:0]  sel_byte;
    logic        r_ok;
    logic        rx_done_ok;
    logic        aw_done;
    logic        w_done;
    logic        unused_rdata_hi;

    always_comb begin
        sel_byte = 8'h00;
        case (axi_sel)
            2'b00:   sel_byte = 8'h99;
            2'b01:   sel_byte = 8'haa;
            2'b10:   sel_byte = tx_data;
            default: sel_byte = 8'h00;
        endcase
    end

    // rready is held for the whole R state, so rvalid there is the handshake
    assign r_ok            = (m_axi.rresp == RESP_OKAY);
    assign rx_done_ok      = (state == RX_R) && m_axi.rvalid && r_ok;
    assign aw_done         = !m_axi.awvalid || m_axi.awready;
    assign w_done          = !m_axi.wvalid || m_axi.wready;
    assign unused_rdata_hi = ^m_axi.rdata[31:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rx_data       <= 8'h00;
            axi_r_success <= 1'b0;
            axi_w_success <= 1'b0;
            axi_w_busy    <= 1'b0;
            m_axi.araddr  <= 4'h0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
            m_axi.awaddr  <= 4'h0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= 32'h0;
            m_axi.wstrb   <= 4'h0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
        end else begin
            axi_r_success <= 1'b0;
            axi_w_success <= 1'b0;
            m_axi.awaddr  <= ADDR_TX;
            m_axi.wstrb   <= 4'h1;
            case (state)
                IDLE: begin
                    if (axi_we) begin
                        m_axi.wdata   <= {24'h0, sel_byte};
                        m_axi.araddr  <= ADDR_STAT;
                        m_axi.arvalid <= 1'b1;
                        axi_w_busy    <= 1'b1;
                        state         <= WS_AR;
                    end else if (axi_re) begin
                        m_axi.araddr  <= ADDR_STAT;
                        m_axi.arvalid <= 1'b1;
                        axi_w_busy    <= 1'b1;
                        state         <= RS_AR;
                    end
                end
                RS_AR, RX_AR, WS_AR: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state <= (state == RS_AR) ? RS_R : (state == RX_AR) ? RX_R : WS_R;
                    end
                end
                RS_R: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        if (r_ok && m_axi.rdata[0]) begin
                            m_axi.araddr  <= ADDR_RX;
                            m_axi.arvalid <= 1'b1;
                            state         <= RX_AR;
                        end else begin
                            axi_w_busy <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                RX_R: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready  <= 1'b0;
                        rx_data       <= m_axi.rdata[7:0];
                        axi_r_success <= r_ok;
                        axi_w_busy    <= 1'b0;
                        state         <= IDLE;
                    end
                end
                WS_R: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        // bit 3 of STAT is TX FIFO full: keep polling until there is room
                        if (r_ok && !m_axi.rdata[3]) begin
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state         <= W_AW;
                        end else begin
                            m_axi.araddr  <= ADDR_STAT;
                            m_axi.arvalid <= 1'b1;
                            state         <= WS_AR;
                        end
                    end
                end
                W_AW: begin
                    if (m_axi.awready) m_axi.awvalid <= 1'b0;
                    if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axi.bready <= 1'b1;
                        state        <= W_B;
                    end
                end
                W_B: begin
                    if (m_axi.bvalid) begin
                        m_axi.bready <= 1'b0;
                        if (m_axi.bresp == RESP_OKAY) begin
                            axi_w_success <= 1'b1;
                            axi_w_busy    <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            m_axi.araddr  <= ADDR_STAT;
                            m_axi.arvalid <= 1'b1;
                            state         <= WS_AR;
                        end
                    end
                end
                default: begin
                    axi_w_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Idle-gap watchdog: only armed once a session has delivered a byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter       <= 32'h0;
            armed         <= 1'b0;
            axi_r_timeout <= 1'b0;
        end else begin
            axi_r_timeout <= 1'b0;
            if (!axi_re) begin
                counter <= 32'h0;
                armed   <= 1'b0;
            end else if (rx_done_ok) begin
                counter <= 32'h0;
                armed   <= 1'b1;
            end else if (armed) begin
                if (counter == TIMEOUT_CYCLES - 32'd1) begin
                    axi_r_timeout <= 1'b1;
                    counter       <= 32'h0;
                    armed         <= 1'b0;
                end else begin
                    counter <= counter + 32'd1;
                end
            end
        end
    end
endmodule
